// File: rtl/mdu_pkg.sv
// rtl/mdu_pkg.sv - shared constants, state enum and opcode decode helpers for mdu_seq
package mdu_pkg;

  localparam int XLEN = 32;

  localparam logic [2:0] F3_MUL  = 3'b000;
  localparam logic [2:0] F3_DIV  = 3'b100;
  localparam logic [2:0] F3_DIVU = 3'b101;
  localparam logic [2:0] F3_REM  = 3'b110;
  localparam logic [2:0] F3_REMU = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;

  // Every code with bit 2 set is a divide flavour; anything else runs as MUL.
  function automatic logic f3_is_div(input logic [2:0] f3);
    return f3[2];
  endfunction

  function automatic logic f3_is_rem(input logic [2:0] f3);
    return f3[2] & f3[1];
  endfunction

  function automatic logic f3_is_signed_div(input logic [2:0] f3);
    return f3[2] & ~f3[0];
  endfunction

endpackage

// File: rtl/mdu_divstep.sv
// rtl/mdu_divstep.sv - one combinational restoring-divide step
module mdu_divstep
  import mdu_pkg::*;
(
  input  logic [XLEN:0]   rem_i,
  input  logic            bit_i,
  input  logic [XLEN-1:0] divisor_i,
  output logic [XLEN:0]   rem_o,
  output logic            qbit_o
);

  logic [XLEN+1:0] shifted;
  logic [XLEN+1:0] diff;

  // Shift in the next dividend bit, trial-subtract, keep the difference if it did not borrow.
  always_comb begin
    shifted = {rem_i, bit_i};
    diff    = shifted - {2'b00, divisor_i};
    qbit_o  = ~diff[XLEN+1];
    rem_o   = qbit_o ? diff[XLEN:0] : shifted[XLEN:0];
  end

endmodule

// File: rtl/mdu_seq.sv
// rtl/mdu_seq.sv - sequential RV32M multiply/divide unit; MDU_EARLY_OUT_EN enables MUL early termination
module mdu_seq
  import mdu_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  state_e              state_q, state_d;
  logic [5:0]          count_q;
  logic [2:0]          f3_q;
  logic [2*XLEN-1:0]   mcand_q;
  logic [2*XLEN-1:0]   acc_q;
  logic [XLEN-1:0]     opa_q;
  logic [XLEN:0]       rem_q;
  logic                negq_q;
  logic                negr_q;
  logic [XLEN-1:0]     result_q;

  logic                in_sgn, a_neg, b_neg;
  logic [XLEN-1:0]     a_abs, b_abs;
  logic                div_zero, div_ovf;
  logic [XLEN-1:0]     special_res;

  logic [XLEN:0]       rem_step;
  logic                qbit;
  logic [XLEN-1:0]     quo_step;
  logic [2*XLEN-1:0]   acc_step;
  logic                mul_early;
  logic                run_exit;

  // Decode the incoming op: magnitudes for signed divides and the short-circuit cases.
  always_comb begin
    in_sgn      = f3_is_signed_div(funct3);
    a_neg       = in_sgn & a[XLEN-1];
    b_neg       = in_sgn & b[XLEN-1];
    a_abs       = a_neg ? (~a + 1'b1) : a;
    b_abs       = b_neg ? (~b + 1'b1) : b;
    div_zero    = f3_is_div(funct3) && (b == '0);
    div_ovf     = in_sgn && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    special_res = '0;
    if (div_zero)
      special_res = f3_is_rem(funct3) ? a : 32'hFFFF_FFFF;
    else
      special_res = f3_is_rem(funct3) ? 32'h0000_0000 : 32'h8000_0000;
  end

  mdu_divstep u_divstep (
    .rem_i     (rem_q),
    .bit_i     (opa_q[XLEN-1]),
    .divisor_i (mcand_q[XLEN-1:0]),
    .rem_o     (rem_step),
    .qbit_o    (qbit)
  );

  // One iteration's worth of multiply and divide progress from the current registers.
  always_comb begin
    quo_step = {opa_q[XLEN-2:0], qbit};
    acc_step = acc_q + (opa_q[0] ? mcand_q : '0);
    run_exit = (count_q == 6'd31) | mul_early;
  end

`ifdef MDU_EARLY_OUT_EN
  assign mul_early = ~f3_is_div(f3_q) && (opa_q[XLEN-1:1] == '0);
`else
  assign mul_early = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake outputs; flush overrides everything, including the done pulse.
  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: begin
        busy = start;
        if (start) state_d = (div_zero || div_ovf) ? DONE : RUN;
      end
      RUN: begin
        busy = 1'b1;
        if (run_exit) state_d = f3_is_signed_div(f3_q) ? FIX : DONE;
      end
      FIX: begin
        busy    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
      done    = 1'b0;
    end
  end

  // Operand latching, per-cycle iteration, sign fix-up and result capture; frozen while flushing.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      f3_q     <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      opa_q    <= '0;
      rem_q    <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= '0;
    end else if (!flush) begin
      case (state_q)
        IDLE: begin
          if (start) begin
            f3_q    <= funct3;
            count_q <= '0;
            acc_q   <= '0;
            rem_q   <= '0;
            negq_q  <= a_neg ^ b_neg;
            negr_q  <= a_neg;
            if (f3_is_div(funct3)) begin
              opa_q   <= a_abs;
              mcand_q <= {{XLEN{1'b0}}, b_abs};
            end else begin
              opa_q   <= b;
              mcand_q <= {{XLEN{1'b0}}, a};
            end
            if (div_zero || div_ovf) result_q <= special_res;
          end
        end
        RUN: begin
          count_q <= count_q + 6'd1;
          if (f3_is_div(f3_q)) begin
            opa_q <= quo_step;
            rem_q <= rem_step;
          end else begin
            acc_q   <= acc_step;
            opa_q   <= opa_q >> 1;
            mcand_q <= mcand_q << 1;
          end
          if (run_exit && !f3_is_signed_div(f3_q)) begin
            if (!f3_is_div(f3_q))     result_q <= acc_step[XLEN-1:0];
            else if (f3_is_rem(f3_q)) result_q <= rem_step[XLEN-1:0];
            else                      result_q <= quo_step;
          end
        end
        FIX: begin
          if (f3_is_rem(f3_q))
            result_q <= negr_q ? (~rem_q[XLEN-1:0] + 1'b1) : rem_q[XLEN-1:0];
          else
            result_q <= negq_q ? (~opa_q + 1'b1) : opa_q;
        end
        default: ;
      endcase
    end
  end

  assign result = result_q;

endmodule
